// File: rtl/axi_sram_slave_if.sv
// AXI3-subset bus between a master and the single-port SRAM slave.
// Address, data and response channels are bundled here; clk/rst stay outside.
interface axi_sram_slave_if #(
  parameter int ID_W = 4
) ();
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic            awvalid;
  logic            awready;

  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport slave (
    input  arid, araddr, arlen, arvalid, rready,
    input  awid, awaddr, awlen, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );

  modport master (
    output arid, araddr, arlen, arvalid, rready,
    output awid, awaddr, awlen, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3-subset SRAM slave: one burst outstanding at a time, INCR bursts of
// 32-bit beats, address wraps within the memory and upper bits alias.
module axi_sram_slave #(
  parameter int DEPTH_LOG2 = 10,
  parameter int ID_W       = 4
) (
  input logic              clk,
  input logic              rst,
  axi_sram_slave_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR_DATA, WR_RESP} state_t;

  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

  state_t                state;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            cnt;
  logic [ID_W-1:0]       rid_q;
  logic [ID_W-1:0]       bid_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  ar_hs;
  logic                  aw_hs;
  logic                  r_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  unused;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Reads take priority: awready drops as soon as a read request is pending.
  assign bus.awready = (state == IDLE) && !bus.arvalid;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rid     = rid_q;
  assign bus.rdata   = mem[idx];
  assign bus.rresp   = 2'b00;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;

  assign ar_hs = bus.arvalid && arready_q;
  assign aw_hs = bus.awvalid && bus.awready;
  assign r_hs  = rvalid_q && bus.rready;
  assign w_hs  = bus.wvalid && wready_q;
  assign b_hs  = bvalid_q && bus.bready;

  assign unused = ^{bus.araddr[31:DEPTH_LOG2+2], bus.araddr[1:0],
                    bus.awaddr[31:DEPTH_LOG2+2], bus.awaddr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      rid_q     <= '0;
      bid_q     <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            rid_q     <= bus.arid;
            idx       <= bus.araddr[DEPTH_LOG2+1:2];
            cnt       <= bus.arlen;
            rvalid_q  <= 1'b1;
            rlast_q   <= (bus.arlen == 4'd0);
            arready_q <= 1'b0;
            state     <= RD;
          end else if (aw_hs) begin
            bid_q     <= bus.awid;
            idx       <= bus.awaddr[DEPTH_LOG2+1:2];
            cnt       <= bus.awlen;
            wready_q  <= 1'b1;
            arready_q <= 1'b0;
            state     <= WR_DATA;
          end
        end
        RD: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              state     <= IDLE;
            end else begin
              idx     <= idx + IDX_ONE;
              cnt     <= cnt - 4'd1;
              rlast_q <= (cnt == 4'd1);
            end
          end
        end
        // A burst ends on wlast or on its final counted beat; only both together is OKAY.
        WR_DATA: begin
          if (w_hs) begin
            idx <= idx + IDX_ONE;
            if (bus.wlast || cnt == 4'd0) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (bus.wlast && cnt == 4'd0) ? 2'b00 : 2'b10;
              state    <= WR_RESP;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            bvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is never cleared, so beats written before a reset survive it.
  always_ff @(posedge clk) begin
    if (!rst && state == WR_DATA && w_hs) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.wstrb[k]) mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized scoreboard bench for axi_sram_slave: a word-array reference memory
// predicts read data and write responses, a negedge monitor compares them.
module tb_axi_sram_slave;

  localparam int DEPTH_LOG2 = 10;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int TIMEOUT    = 200;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } rexp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  logic clk;
  logic rst;

  axi_sram_slave_if #(.ID_W(4)) bus ();

  axi_sram_slave #(.DEPTH_LOG2(DEPTH_LOG2), .ID_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] refMem [DEPTH];
  rexp_t       rq [$];
  bexp_t       bq [$];
  int          tests = 0;
  int          fails = 0;

  rexp_t       me;
  bexp_t       mb;
  logic        stallPending = 1'b0;
  logic [31:0] stallData;
  logic        stallLast;
  logic [3:0]  stallId;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: compares every accepted R and B beat, and checks R stays stable while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stallPending = 1'b0;
    end else begin
      if (stallPending && bus.rvalid) begin
        checkOutput("stall_rdata", bus.rdata, stallData);
        checkOutput("stall_rlast", 32'(bus.rlast), 32'(stallLast));
        checkOutput("stall_rid", 32'(bus.rid), 32'(stallId));
      end
      stallPending = bus.rvalid && !bus.rready;
      stallData    = bus.rdata;
      stallLast    = bus.rlast;
      stallId      = bus.rid;
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) begin
          checkOutput("r_unexpected", 0, 1);
        end else begin
          me = rq.pop_front();
          checkOutput("rdata", bus.rdata, me.data);
          checkOutput("rlast", 32'(bus.rlast), 32'(me.last));
          checkOutput("rid", 32'(bus.rid), 32'(me.id));
          checkOutput("rresp", 32'(bus.rresp), 0);
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) begin
          checkOutput("b_unexpected", 0, 1);
        end else begin
          mb = bq.pop_front();
          checkOutput("bresp", 32'(bus.bresp), 32'(mb.resp));
          checkOutput("bid", 32'(bus.bid), 32'(mb.id));
        end
      end
    end
  end

  // Sends a write burst; wlast goes on beat lastpos, the burst stops at min(lastpos, len)+1 beats.
  task automatic writeBurst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input int lastpos, input logic [31:0] d0, input logic [3:0] s0,
                            input bit rndStrb);
    int nsent;
    int t;
    int idx;
    logic [31:0] d;
    logic [3:0]  s;
    nsent = (lastpos < int'(len)) ? lastpos + 1 : int'(len) + 1;
    idx   = int'(addr[31:2]) % DEPTH;
    @(posedge clk); #1;
    bus.awid    = id;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.awready && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (t >= TIMEOUT) begin
      checkOutput("aw_timeout", 0, 1);
      bus.awvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int b = 0; b < nsent; b++) begin
      d = (b == 0) ? d0 : $urandom;
      s = (b == 0) ? s0 : (rndStrb ? 4'($urandom) : 4'hF);
      bus.wdata  = d;
      bus.wstrb  = s;
      bus.wlast  = (b == lastpos);
      bus.wvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.wready && t < TIMEOUT) begin
        @(negedge clk);
        t++;
      end
      if (t >= TIMEOUT) begin
        checkOutput("w_timeout", 0, 1);
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        return;
      end
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (s[k]) refMem[idx][8*k +: 8] = d[8*k +: 8];
      end
      idx = (idx + 1) % DEPTH;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    bq.push_back('{id: id, resp: (lastpos == int'(len)) ? 2'b00 : 2'b10});
    checkOutput("bvalid_after_last_beat", 32'(bus.bvalid), 1);
    checkOutput("wready_after_last_beat", 32'(bus.wready), 0);
    t = 0;
    @(negedge clk);
    while (!(bus.bvalid && bus.bready) && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (t >= TIMEOUT) begin
      checkOutput("b_timeout", 0, 1);
      return;
    end
    @(posedge clk); #1;
  endtask

  // Issues a read burst; toggle alternates rready each cycle to create stalls.
  task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input bit toggle);
    int  t;
    int  iters;
    int  beats;
    int  idx;
    bit  done;
    idx = int'(addr[31:2]) % DEPTH;
    @(posedge clk); #1;
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arvalid = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      rq.push_back('{id: id, data: refMem[(idx + b) % DEPTH], last: (b == int'(len))});
    end
    t = 0;
    @(negedge clk);
    while (!bus.arready && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (t >= TIMEOUT) begin
      checkOutput("ar_timeout", 0, 1);
      bus.arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    iters = 0;
    beats = 0;
    done  = 1'b0;
    while (!done && iters < TIMEOUT) begin
      @(negedge clk);
      iters++;
      if (bus.rvalid && bus.rready) begin
        beats++;
        if (bus.rlast) done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
        if (toggle) bus.rready = !bus.rready;
      end
    end
    if (!done) checkOutput("r_timeout", 0, 1);
    if (!toggle) checkOutput("read_cycles", iters, int'(len) + 1);
    checkOutput("read_beats", beats, int'(len) + 1);
    @(posedge clk); #1;
    bus.rready = 1'b1;
    checkOutput("arready_after_read", 32'(bus.arready), 1);
    checkOutput("rvalid_after_read", 32'(bus.rvalid), 0);
  endtask

  // Random mix of reads and writes over the full 32-bit address space.
  task automatic applyStimulus(input int n);
    logic [3:0]  len;
    logic [31:0] addr;
    int          lastpos;
    for (int i = 0; i < n; i++) begin
      len  = 4'($urandom_range(0, 15));
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        lastpos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'(len);
        writeBurst(4'($urandom), addr, len, lastpos, $urandom, 4'($urandom), 1'b1);
      end else begin
        readBurst(4'($urandom), addr, len, 1'($urandom));
      end
    end
  endtask

  initial begin
    int t;
    int cnt;
    rst         = 1'b1;
    bus.arid    = '0;
    bus.araddr  = '0;
    bus.arlen   = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    bus.awid    = '0;
    bus.awaddr  = '0;
    bus.awlen   = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wlast   = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_arready", 32'(bus.arready), 1);
    checkOutput("reset_awready", 32'(bus.awready), 1);
    checkOutput("reset_rvalid", 32'(bus.rvalid), 0);
    checkOutput("reset_rlast", 32'(bus.rlast), 0);
    checkOutput("reset_wready", 32'(bus.wready), 0);
    checkOutput("reset_bvalid", 32'(bus.bvalid), 0);
    checkOutput("reset_rid", 32'(bus.rid), 0);
    checkOutput("reset_bid", 32'(bus.bid), 0);
    checkOutput("reset_bresp", 32'(bus.bresp), 0);

    for (int i = 0; i < DEPTH / 16; i++) begin
      writeBurst(4'(i), 32'(i * 64), 4'd15, 15, $urandom, 4'hF, 1'b0);
    end

    writeBurst(4'd1, 32'h10, 4'd0, 0, 32'hDEADBEEF, 4'hF, 1'b0);
    readBurst(4'd2, 32'h10, 4'd0, 1'b0);
    readBurst(4'd3, 32'h0, 4'd3, 1'b0);
    writeBurst(4'd4, 32'h10, 4'd0, 0, 32'h0000AB00, 4'b0010, 1'b0);
    readBurst(4'd5, 32'h10, 4'd0, 1'b0);

    fork
      readBurst(4'd6, 32'h40, 4'd3, 1'b1);
      writeBurst(4'd7, 32'h80, 4'd1, 1, $urandom, 4'hF, 1'b0);
      begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("awready_on_tie", 32'(bus.awready), 0);
        @(negedge clk);
        checkOutput("awready_during_read", 32'(bus.awready), 0);
      end
    join
    readBurst(4'd8, 32'h80, 4'd1, 1'b0);

    writeBurst(4'd9, 32'h200, 4'd3, 1, $urandom, 4'hF, 1'b0);
    readBurst(4'd10, 32'h200, 4'd3, 1'b0);
    writeBurst(4'd11, 32'h300, 4'd1, 5, $urandom, 4'hF, 1'b0);
    readBurst(4'd12, 32'(DEPTH - 1) * 4, 4'd1, 1'b0);
    readBurst(4'd13, 32'hFFF0_0000 | 32'h300, 4'd1, 1'b0);

    // Reset while the third beat of a four-beat read is on the bus.
    @(posedge clk); #1;
    bus.arid    = 4'd14;
    bus.araddr  = 32'h100;
    bus.arlen   = 4'd3;
    bus.arvalid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      rq.push_back('{id: 4'd14, data: refMem[64 + b], last: (b == 3)});
    end
    t = 0;
    @(negedge clk);
    while (!bus.arready && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    cnt = 0;
    t   = 0;
    while (cnt < 3 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
      if (bus.rvalid && bus.rready) cnt++;
      if (cnt < 3) begin
        @(posedge clk); #1;
      end
    end
    checkOutput("beats_before_reset", cnt, 3);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midburst_rvalid", 32'(bus.rvalid), 0);
    checkOutput("midburst_arready", 32'(bus.arready), 1);
    checkOutput("midburst_rlast", 32'(bus.rlast), 0);
    checkOutput("midburst_rid", 32'(bus.rid), 0);
    rq.delete();
    rst = 1'b0;
    readBurst(4'd15, 32'h100, 4'd3, 1'b0);

    applyStimulus(80);

    t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    checkOutput("rq_drained", rq.size(), 0);
    checkOutput("bq_drained", bq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
